id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the RISC-V core, feeding the ALU directly. It registers decoded operands and control on each clock and resolves EX/MEM and MEM/WB forwarding. It drives the ALU's two 32-bit operand inputs and 3-bit control, and produces the store-data path. It detects load-use hazards and inserts a bubble on its own; stall and flush requests come from the hazard/branch logic.

## Interface
- DATA_W, 32, operand/result width
- REG_W, 5, register-address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- stall_i  in  1  hold all registered fields
- flush_i  in  1  load a bubble
- id_valid_i  in  1  ID holds a real instruction
- rs1_data_i, rs2_data_i, imm_i  in  DATA_W  register-file reads, sign-extended immediate
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  REG_W  source/destination indices
- alu_ctrl_i  in  3  ALU op code
- alu_src_i  in  1  1 = imm replaces rs2 as operand 2
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  1  downstream control
- exmem_reg_write_i, memwb_reg_write_i  in  1  writer valid in EX/MEM, MEM/WB
- exmem_rd_i, memwb_rd_i  in  REG_W  writer destinations
- exmem_data_i, memwb_data_i  in  DATA_W  forwarded values
- data1_o, data2_o  out  DATA_W  ALU operands
- alu_ctrl_o  out  3  to ALU
- store_data_o  out  DATA_W  forwarded rs2 for stores
- rd_addr_o  out  REG_W; reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o  out  1
- hazard_o  out  1  load-use hazard; upstream must hold PC and IF/ID

## Operation
- Registered fields: valid, rs1/rs2 data, imm, rs1/rs2/rd addr, alu_ctrl, alu_src, four control bits.
- Update priority at each rising edge: rst_i > flush_i > stall_i > hazard_o > normal load.
  - flush_i: load a bubble.
  - stall_i: hold every field.
  - hazard_o (without stall/flush): load a bubble.
  - Otherwise: load every field from the ID inputs, with valid = id_valid_i.
- Bubble: every registered field set to zero. valid = 0 and all control = 0, so there are no side effects downstream.
- hazard_o = valid_q & mem_read_q & (rd_q != 0) & id_valid_i & (rd_q == rs1_addr_i | rd_q == rs2_addr_i). It is purely combinational.
- Forwarding, applied per source (rs1 and rs2) on the registered address:
  - If exmem_reg_write_i & exmem_rd_i != 0 & exmem_rd_i == addr, use exmem_data_i.
  - Else if the same test passes for memwb, use memwb_data_i.
  - Else use the registered data.
  - EX/MEM wins when both match. x0 is never forwarded.
- Outputs:
  - data1_o = fwd_rs1.
  - data2_o = alu_src_q ? imm_q : fwd_rs2.
  - store_data_o = fwd_rs2, always, regardless of alu_src.
- No arithmetic is performed here. All widths pass through unchanged; imm arrives already sign-extended.

## Timing
- Reset: every registered field is 0, so valid_o, all control, rd_addr_o, alu_ctrl_o (3'b000) and hazard_o are 0. data1_o/data2_o/store_data_o read 0 unless a forward matches, and a forward cannot match because rs addrs are 0.
- rst_i mid-operation clears the stage immediately, asynchronously, without waiting for a clock edge.
- Latency: ID inputs appear on the outputs 1 cycle after the capturing edge.
- Forward selection and the data1/data2 muxes are combinational in the same cycle as the exmem/memwb inputs.
- Load-use: the load sits in this stage and the dependent instruction in ID. hazard_o is high for exactly one cycle, after which a bubble is present. The next edge then loads the dependent instruction, and it takes its value from MEM/WB forwarding.
- stall_i together with hazard_o: hold wins, and hazard_o stays high while the condition persists.
- flush_i together with stall_i: flush wins.

## Structure
- Shared package riscv_pkg:
  - DATA_W/REG_W constants.
  - ALU op codes: AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, ADDI 110, SRAI 111.
  - Also consumed by the ALU and its control decoder.
- Sub-module fwd_mux: the 3-way forward select for one source, instantiated twice (rs1, rs2).

## Test plan
- Reset then release, no stimulus: all outputs 0, hazard_o 0; assert rst_i mid-stream and all fields clear without a clock edge.
- Plain load: rs1_data 0x5, rs2_data 0x7, alu_ctrl ADD, alu_src 0 -> next cycle data1_o 0x5, data2_o 0x7, alu_ctrl_o 3'b011; with alu_src 1 and imm 0xFFFFFFFC -> data2_o 0xFFFFFFFC, store_data_o 0x7.
- Forwarding with rs1 = x3:
  - exmem_rd 3 with data 0xAA and memwb_rd 3 with data 0xBB, both writing -> data1_o 0xAA.
  - Drop exmem_reg_write -> data1_o 0xBB.
  - rs1 = x0 with exmem_rd 0 -> registered value kept.
- Load-use: lw x5 in stage (mem_read 1, rd 5), ID add with rs2 x5 -> hazard_o 1; next cycle valid_o 0, all control 0; following edge loads the add.
- stall_i for 3 cycles with changing ID inputs -> outputs frozen; release -> new instruction loaded next edge.
- flush_i and stall_i together -> bubble loaded (valid_o 0, reg_write_o 0, mem_write_o 0).

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core widths, ALU op codes and ID/EX register layout
package riscv_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_XOR  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_ADDI = 3'b110,
    ALU_SRAI = 3'b111
  } alu_op_e;

  // All-zero value of this struct is the bubble: no valid, no side effects.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs1_addr;
    logic [REG_W-1:0]  rs2_addr;
    logic [REG_W-1:0]  rd_addr;
    logic [2:0]        alu_ctrl;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - three-way forwarding select for one source operand
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [REG_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_W-1:0]  exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_W-1:0]  memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic exmem_hit;
  logic memwb_hit;

  // x0 is hardwired zero, so a write targeting it never forwards.
  assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == addr_i);
  assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == addr_i);

  always_comb begin
    data_o = reg_data_i;
    if (exmem_hit) begin
      data_o = exmem_data_i;
    end else if (memwb_hit) begin
      data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and load-use bubble insertion
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_W-1:0]  rs1_addr_i,
  input  logic [REG_W-1:0]  rs2_addr_i,
  input  logic [REG_W-1:0]  rd_addr_i,
  input  logic [2:0]        alu_ctrl_i,
  input  logic              alu_src_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic              exmem_reg_write_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_W-1:0]  exmem_rd_i,
  input  logic [REG_W-1:0]  memwb_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [2:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [REG_W-1:0]  rd_addr_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_to_reg_o,
  output logic              valid_o,
  output logic              hazard_o
);

  id_ex_t stage_q;
  id_ex_t stage_d;
  logic [DATA_W-1:0] fwd_rs1;
  logic [DATA_W-1:0] fwd_rs2;

  // A load sitting here cannot supply its data to the instruction in ID yet.
  assign hazard_o = stage_q.valid && stage_q.mem_read && (stage_q.rd_addr != '0) &&
                    id_valid_i &&
                    ((stage_q.rd_addr == rs1_addr_i) || (stage_q.rd_addr == rs2_addr_i));

  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      stage_d = '0;
    end else if (stall_i) begin
      stage_d = stage_q;
    end else if (hazard_o) begin
      stage_d = '0;
    end else begin
      stage_d.valid      = id_valid_i;
      stage_d.rs1_data   = rs1_data_i;
      stage_d.rs2_data   = rs2_data_i;
      stage_d.imm        = imm_i;
      stage_d.rs1_addr   = rs1_addr_i;
      stage_d.rs2_addr   = rs2_addr_i;
      stage_d.rd_addr    = rd_addr_i;
      stage_d.alu_ctrl   = alu_ctrl_i;
      stage_d.alu_src    = alu_src_i;
      stage_d.reg_write  = reg_write_i;
      stage_d.mem_read   = mem_read_i;
      stage_d.mem_write  = mem_write_i;
      stage_d.mem_to_reg = mem_to_reg_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  fwd_mux u_fwd_rs1 (
    .addr_i            (stage_q.rs1_addr),
    .reg_data_i        (stage_q.rs1_data),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_data_i      (exmem_data_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_data_i      (memwb_data_i),
    .data_o            (fwd_rs1)
  );

  fwd_mux u_fwd_rs2 (
    .addr_i            (stage_q.rs2_addr),
    .reg_data_i        (stage_q.rs2_data),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_data_i      (exmem_data_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_data_i      (memwb_data_i),
    .data_o            (fwd_rs2)
  );

  assign data1_o      = fwd_rs1;
  assign data2_o      = stage_q.alu_src ? stage_q.imm : fwd_rs2;
  assign store_data_o = fwd_rs2;
  assign alu_ctrl_o   = stage_q.alu_ctrl;
  assign rd_addr_o    = stage_q.rd_addr;
  assign reg_write_o  = stage_q.reg_write;
  assign mem_read_o   = stage_q.mem_read;
  assign mem_write_o  = stage_q.mem_write;
  assign mem_to_reg_o = stage_q.mem_to_reg;
  assign valid_o      = stage_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              stall_i, flush_i, id_valid_i;
  logic [DATA_W-1:0] rs1_data_i, rs2_data_i, imm_i;
  logic [REG_W-1:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [2:0]        alu_ctrl_i;
  logic              alu_src_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
  logic              exmem_reg_write_i, memwb_reg_write_i;
  logic [REG_W-1:0]  exmem_rd_i, memwb_rd_i;
  logic [DATA_W-1:0] exmem_data_i, memwb_data_i;
  logic [DATA_W-1:0] data1_o, data2_o, store_data_o;
  logic [2:0]        alu_ctrl_o;
  logic [REG_W-1:0]  rd_addr_o;
  logic              reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o, hazard_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_addr_i(rd_addr_i), .alu_ctrl_i(alu_ctrl_i), .alu_src_i(alu_src_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_to_reg_i(mem_to_reg_i), .exmem_reg_write_i(exmem_reg_write_i),
    .memwb_reg_write_i(memwb_reg_write_i), .exmem_rd_i(exmem_rd_i),
    .memwb_rd_i(memwb_rd_i), .exmem_data_i(exmem_data_i), .memwb_data_i(memwb_data_i),
    .data1_o(data1_o), .data2_o(data2_o), .alu_ctrl_o(alu_ctrl_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
    .valid_o(valid_o), .hazard_o(hazard_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 0; flush_i = 0; id_valid_i = 0;
    rs1_data_i = 0; rs2_data_i = 0; imm_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0; alu_ctrl_i = 0;
    alu_src_i = 0; reg_write_i = 0; mem_read_i = 0; mem_write_i = 0; mem_to_reg_i = 0;
    exmem_reg_write_i = 0; memwb_reg_write_i = 0; exmem_rd_i = 0; memwb_rd_i = 0;
    exmem_data_i = 0; memwb_data_i = 0;

    step(); step();
    rst_i = 1'b0;
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_data1", data1_o, 0);
    check("rst_data2", data2_o, 0);
    check("rst_store", store_data_o, 0);
    check("rst_alu_ctrl", alu_ctrl_o, 0);
    check("rst_rd", rd_addr_o, 0);
    check("rst_hazard", hazard_o, 0);
    step();
    check("idle_valid", valid_o, 0);
    check("idle_regwrite", reg_write_o, 0);

    // Plain register-register ADD
    id_valid_i = 1; rs1_data_i = 32'h5; rs2_data_i = 32'h7; alu_ctrl_i = ALU_ADD;
    alu_src_i = 0; rs1_addr_i = 1; rs2_addr_i = 2; rd_addr_i = 1; reg_write_i = 1;
    step();
    check("plain_data1", data1_o, 32'h5);
    check("plain_data2", data2_o, 32'h7);
    check("plain_alu_ctrl", alu_ctrl_o, 3'b011);
    check("plain_valid", valid_o, 1);
    check("plain_regwrite", reg_write_o, 1);
    check("plain_rd", rd_addr_o, 1);

    // Immediate operand replaces rs2 on the ALU path only
    alu_src_i = 1; imm_i = 32'hFFFF_FFFC;
    step();
    check("imm_data2", data2_o, 32'hFFFF_FFFC);
    check("imm_store", store_data_o, 32'h7);

    // Asynchronous reset between edges
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_data1", data1_o, 0);
    check("arst_regwrite", reg_write_o, 0);
    check("arst_data2", data2_o, 0);
    rst_i = 1'b0;

    // Forwarding on rs1 = x3, rs2 = x4
    alu_src_i = 0; imm_i = 0; rs1_addr_i = 3; rs1_data_i = 32'h11;
    rs2_addr_i = 4; rs2_data_i = 32'h22; rd_addr_i = 6;
    step();
    exmem_reg_write_i = 1; exmem_rd_i = 3; exmem_data_i = 32'hAA;
    memwb_reg_write_i = 1; memwb_rd_i = 3; memwb_data_i = 32'hBB;
    #1;
    check("fwd_exmem_wins", data1_o, 32'hAA);
    check("fwd_rs2_none", data2_o, 32'h22);
    exmem_reg_write_i = 0;
    #1;
    check("fwd_memwb", data1_o, 32'hBB);
    memwb_rd_i = 4;
    #1;
    check("fwd_rs1_back", data1_o, 32'h11);
    check("fwd_rs2_data2", data2_o, 32'hBB);
    check("fwd_rs2_store", store_data_o, 32'hBB);
    exmem_reg_write_i = 0; memwb_reg_write_i = 0; exmem_rd_i = 0; memwb_rd_i = 0;

    // x0 is never forwarded
    rs1_addr_i = 0; rs1_data_i = 32'h33;
    step();
    exmem_reg_write_i = 1; exmem_rd_i = 0; exmem_data_i = 32'hAA;
    memwb_reg_write_i = 1; memwb_rd_i = 0; memwb_data_i = 32'hBB;
    #1;
    check("fwd_x0", data1_o, 32'h33);
    exmem_reg_write_i = 0; memwb_reg_write_i = 0;

    // Load-use: lw x5 then add using x5 as rs2
    mem_read_i = 1; mem_to_reg_i = 1; reg_write_i = 1; rd_addr_i = 5;
    rs1_addr_i = 1; rs2_addr_i = 0; alu_src_i = 1; imm_i = 32'h4; alu_ctrl_i = ALU_ADD;
    step();
    mem_read_i = 0; mem_to_reg_i = 0; rd_addr_i = 7; rs1_addr_i = 6; rs2_addr_i = 5;
    alu_src_i = 0; imm_i = 0; rs1_data_i = 32'h10; rs2_data_i = 32'h99;
    #1;
    check("lu_hazard", hazard_o, 1);
    check("lu_load_valid", valid_o, 1);
    step();
    check("lu_bubble_valid", valid_o, 0);
    check("lu_bubble_regwrite", reg_write_o, 0);
    check("lu_bubble_memread", mem_read_o, 0);
    check("lu_bubble_memtoreg", mem_to_reg_o, 0);
    check("lu_bubble_alu", alu_ctrl_o, 0);
    check("lu_bubble_rd", rd_addr_o, 0);
    check("lu_hazard_clear", hazard_o, 0);
    step();
    memwb_reg_write_i = 1; memwb_rd_i = 5; memwb_data_i = 32'h1234;
    #1;
    check("lu_add_valid", valid_o, 1);
    check("lu_add_rd", rd_addr_o, 7);
    check("lu_add_data1", data1_o, 32'h10);
    check("lu_add_data2_fwd", data2_o, 32'h1234);
    memwb_reg_write_i = 0; memwb_rd_i = 0; memwb_data_i = 0;

    // Stall three cycles while ID keeps changing
    stall_i = 1; alu_ctrl_i = ALU_SUB; rd_addr_i = 9;
    for (int i = 0; i < 3; i++) begin
      rs1_data_i = 32'hD00 + i;
      step();
      check("stall_data1", data1_o, 32'h10);
      check("stall_rd", rd_addr_o, 7);
      check("stall_alu", alu_ctrl_o, 3'b011);
    end
    stall_i = 0;
    step();
    check("unstall_data1", data1_o, 32'hD02);
    check("unstall_rd", rd_addr_o, 9);
    check("unstall_alu", alu_ctrl_o, 3'b100);

    // Stall with a pending load-use hazard: hold wins
    mem_read_i = 1; reg_write_i = 1; mem_write_i = 1; rd_addr_i = 5;
    rs1_addr_i = 1; rs2_addr_i = 2;
    step();
    mem_read_i = 0; mem_write_i = 0; rd_addr_i = 8; rs1_addr_i = 5; stall_i = 1;
    #1;
    check("sh_hazard", hazard_o, 1);
    step();
    check("sh_hazard_held", hazard_o, 1);
    check("sh_memread_held", mem_read_o, 1);
    check("sh_rd_held", rd_addr_o, 5);

    // Flush together with stall: flush wins
    flush_i = 1;
    step();
    check("fl_valid", valid_o, 0);
    check("fl_regwrite", reg_write_o, 0);
    check("fl_memwrite", mem_write_o, 0);
    check("fl_memread", mem_read_o, 0);
    check("fl_hazard", hazard_o, 0);
    flush_i = 0; stall_i = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
